// File: rtl/decoder_scheduler_if.sv
// Bundle of the requester-side and decoder-side signals around decoder_scheduler.
// The scheduler binds to the slave modport; whoever drives requests and decoder results uses master.
interface decoder_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int ENC_WIDTH = 16
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*ENC_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic                         dec_load;
  logic [ENC_WIDTH-1:0]         dec_encodedData;
  logic                         dec_ready;
  logic [31:0]                  dec_decodedData;
  logic [3:0]                   dec_symbolLength;
  logic [31:0]                  out_data;
  logic [3:0]                   out_length;
  logic                         busy;
  logic                         timeout_err;

  modport master (
    output req, req_data, dec_ready, dec_decodedData, dec_symbolLength,
    input  grant, done, dec_load, dec_encodedData, out_data, out_length, busy, timeout_err
  );

  modport slave (
    input  req, req_data, dec_ready, dec_decodedData, dec_symbolLength,
    output grant, done, dec_load, dec_encodedData, out_data, out_length, busy, timeout_err
  );
endinterface

// File: rtl/decoder_scheduler.sv
// Round-robin scheduler sharing one Huffman decoder among NUM_REQ requesters.
// Each job runs IDLE -> LOAD -> WAIT -> DONE, aborting with timeout_err if the decoder stalls.
module decoder_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ENC_WIDTH = 16,
  parameter int TIMEOUT   = 15
) (
  input logic clk,
  input logic rst,
  decoder_scheduler_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] sel_q;
  logic [PW-1:0] pick;
  logic          pick_valid;
  logic [CW-1:0] cnt;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    idx        = 0;
    idx_p      = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_p = PW'(idx);
      if (!pick_valid && bus.req[idx_p]) begin
        pick       = idx_p;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      sel_q               <= '0;
      cnt                 <= '0;
      bus.grant           <= '0;
      bus.done            <= '0;
      bus.dec_load        <= 1'b0;
      bus.dec_encodedData <= '0;
      bus.out_data        <= '0;
      bus.out_length      <= '0;
      bus.busy            <= 1'b0;
      bus.timeout_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.grant           <= NUM_REQ'(1) << pick;
            sel_q               <= pick;
            bus.dec_encodedData <= bus.req_data[int'(pick)*ENC_WIDTH +: ENC_WIDTH];
            bus.busy            <= 1'b1;
            state               <= LOAD;
          end
        end
        LOAD: begin
          bus.dec_load <= 1'b1;
          cnt          <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          bus.dec_load <= 1'b0;
          // Ready wins over a timeout landing on the same cycle.
          if (bus.dec_ready) begin
            bus.out_data   <= bus.dec_decodedData;
            bus.out_length <= bus.dec_symbolLength;
            bus.done       <= bus.grant;
            state          <= DONE;
          end else if (cnt == CNT_LAST) begin
            cnt             <= cnt + 1'b1;
            bus.out_data    <= '0;
            bus.out_length  <= '0;
            bus.timeout_err <= 1'b1;
            bus.done        <= bus.grant;
            state           <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.done        <= '0;
          bus.timeout_err <= 1'b0;
          bus.grant       <= '0;
          bus.busy        <= 1'b0;
          rr_ptr          <= (sel_q == PTR_LAST) ? '0 : sel_q + 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/decoder_scheduler.md
DECODER_SCHEDULER -- requirements
Module: decoder_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one HuffmanDecoder instance.
REQ-002 Parameter ENC_WIDTH, default 16: width of one encoded-data window per requester.
REQ-003 Parameter TIMEOUT, default 15: maximum WAIT cycles before a job is aborted.
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_REQ  level request per requester; held until done.
REQ-008 req_data  input  NUM_REQ*ENC_WIDTH  encoded windows; requester i at slice [i*ENC_WIDTH +: ENC_WIDTH].
REQ-009 grant  output  NUM_REQ  one-hot owner of the decoder; zero when idle.
REQ-010 done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-011 dec_load  output  1  load strobe to the decoder.
REQ-012 dec_encodedData  output  ENC_WIDTH  window driven to the decoder.
REQ-013 dec_ready  input  1  decoder result valid.
REQ-014 dec_decodedData  input  32  decoder symbol.
REQ-015 dec_symbolLength  input  4  decoder code length.
REQ-016 out_data  output  32  captured symbol, valid with done.
REQ-017 out_length  output  4  captured length, valid with done; 0 on timeout.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 timeout_err  output  1  one-cycle pulse coincident with done on an aborted job.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, WAIT, DONE; all outputs registered.
REQ-021 IDLE: if any req bit is set, grant the first set bit at or after rr_ptr (wrapping modulo NUM_REQ), latch that requester's req_data into dec_encodedData, go to LOAD; otherwise stay.
REQ-022 LOAD: dec_load=1 for exactly one cycle, wait counter cleared, go to WAIT.
REQ-023 WAIT: on dec_ready=1, capture out_data/out_length and go to DONE; the counter increments each cycle without ready.
REQ-024 WAIT: when the counter reaches TIMEOUT without ready, set out_data=0, out_length=0, assert timeout_err in DONE, and go to DONE.
REQ-025 DONE: done[granted]=1 for one cycle, rr_ptr = granted index + 1 (wrapping), grant cleared, return to IDLE.
REQ-026 Job latency SHALL be 3 cycles + decoder wait: grant in the cycle after IDLE sampling, load in the next cycle, done in the cycle after dec_ready is sampled.
REQ-027 dec_ready in IDLE, LOAD, or DONE SHALL be ignored.
REQ-028 Withdrawal of req by the owner mid-job SHALL NOT abort the job; done still pulses.
REQ-029 Changes to req_data after grant SHALL NOT affect dec_encodedData.
REQ-030 A requester whose job completes SHALL be lowest priority in the next arbitration (no back-to-back grant while others request).
REQ-031 The wait counter SHALL be $clog2(TIMEOUT+1) bits and SHALL NOT wrap.

Reset
REQ-032 rst=0 SHALL immediately force IDLE, rr_ptr=0, counter=0, grant=0, done=0, dec_load=0, dec_encodedData=0, out_data=0, out_length=0, busy=0, timeout_err=0.
REQ-033 Reset asserted mid-job SHALL drop the job with no done pulse; first arbitration after release starts at requester 0.

Verification
REQ-034 Single request: req=4'b0010, req_data slice1=16'hA5C3, dec_ready 2 cycles after dec_load with data 32'd7, length 4'd5 -> grant=4'b0010, dec_encodedData=16'hA5C3, done=4'b0010 with out_data=7, out_length=5.
REQ-035 Round-robin: req=4'b1111 held for 4 jobs -> grant order 0001, 0010, 0100, 1000, then 0001.
REQ-036 Timeout: req=4'b0001, dec_ready never asserted -> done[0] and timeout_err both high 15 cycles after WAIT entry, out_length=0.
REQ-037 Reset mid-WAIT: rst=0 while grant=4'b0100 -> all outputs 0 asynchronously; after release with req=4'b0100|4'b0001, the first grant is 4'b0001.
REQ-038 Spurious ready: dec_ready=1 in IDLE with req=0 -> no done and outputs unchanged; requester withdraws req during WAIT -> done is still delivered.
